// File: rtl/ysyx_23060096_exec_fsm.sv
// ysyx_23060096_exec_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with write-enable gating
// Ports: clk/rst (sync, active-high); IFU handshake ifu_req/ifu_rvalid/ir_we;
// decoder inputs inst_op/is_ebreak/dec_regwr/dec_memwr; LSU handshake lsu_req/lsu_wen/lsu_ready;
// gated enables rf_we/pc_we; sticky status halt/illegal/bus_err; counters cycle_cnt/instret_cnt.
module ysyx_23060096_exec_fsm #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ifu_req,
    input  logic             ifu_rvalid,
    output logic             ir_we,
    input  logic [6:0]       inst_op,
    input  logic             is_ebreak,
    input  logic             dec_regwr,
    input  logic             dec_memwr,
    output logic             lsu_req,
    output logic             lsu_wen,
    input  logic             lsu_ready,
    output logic             rf_we,
    output logic             pc_we,
    output logic             halt,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    state_t state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic illegal_q, illegal_d, bus_err_q, bus_err_d;
    logic [CNT_W-1:0] cyc_q, ret_q;
    logic op_ok, is_mem, timeout;
    always_comb begin
        op_ok   = inst_op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                  7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011};
        is_mem  = inst_op == 7'b0000011 || inst_op == 7'b0100011;
        // this is the last wait cycle: a handshake now still wins, otherwise the bus is dead
        timeout = wait_q == WW'(MEM_TIMEOUT - 1);
        state_d   = state_q;
        wait_d    = wait_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        ifu_req   = 1'b0;
        ir_we     = 1'b0;
        lsu_req   = 1'b0;
        lsu_wen   = 1'b0;
        rf_we     = 1'b0;
        pc_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                wait_d  = '0;
            end
            S_FETCH: begin
                ifu_req = 1'b1;
                ir_we   = ifu_rvalid;
                if (ifu_rvalid) state_d = S_DECODE;
                else if (timeout) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end else wait_d = wait_q + 1'b1;
            end
            S_DECODE: begin
                if (!op_ok) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end else state_d = is_ebreak ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                state_d = is_mem ? S_MEM : S_WB;
                wait_d  = '0;
            end
            S_MEM: begin
                lsu_req = 1'b1;
                lsu_wen = dec_memwr;
                if (lsu_ready) state_d = S_WB;
                else if (timeout) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end else wait_d = wait_q + 1'b1;
            end
            S_WB: begin
                rf_we   = dec_regwr;
                pc_we   = 1'b1;
                state_d = S_FETCH;
                wait_d  = '0;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            cyc_q     <= '0;
            ret_q     <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            if (state_q != S_IDLE && state_q != S_HALT) cyc_q <= cyc_q + 1'b1;
            if (state_q == S_WB) ret_q <= ret_q + 1'b1;
        end
    end
    assign halt        = state_q == S_HALT;
    assign illegal     = illegal_q;
    assign bus_err     = bus_err_q;
    assign cycle_cnt   = cyc_q;
    assign instret_cnt = ret_q;
endmodule

// File: tb/tb_ysyx_23060096_exec_fsm.sv
// tb_ysyx_23060096_exec_fsm: per-cycle vector table plus wrap and MEM-timeout sequences
module tb_ysyx_23060096_exec_fsm;
    localparam logic [6:0] ADDI = 7'b0010011, LOAD = 7'b0000011, STORE = 7'b0100011;
    localparam logic [6:0] RTYP = 7'b0110011, SYS = 7'b1110011, BAD = 7'b1111111;
    // expected flag order: {ifu_req, ir_we, lsu_req, lsu_wen, rf_we, pc_we, halt, illegal, bus_err}
    localparam logic [8:0] Z  = 9'b000000000, F  = 9'b100000000, FI = 9'b110000000;
    localparam logic [8:0] M  = 9'b001000000, MW = 9'b001100000, WB = 9'b000011000;
    localparam logic [8:0] P  = 9'b000001000, H  = 9'b000000100, HI = 9'b000000110;
    localparam logic [8:0] HB = 9'b000000101;
    typedef struct {
        logic       rst, rv;
        logic [6:0] op;
        logic       eb, rw, mw, rdy;
        logic [8:0] flags;
        logic [3:0] cyc, ret;
    } vec_t;
    logic clk = 1'b0, rst, ifu_rvalid, is_ebreak, dec_regwr, dec_memwr, lsu_ready;
    logic [6:0] inst_op;
    logic ifu_req, ir_we, lsu_req, lsu_wen, rf_we, pc_we, halt, illegal, bus_err;
    logic [3:0] cycle_cnt, instret_cnt;
    vec_t vecs[$];
    int applied = 0, miscompares = 0;
    always #5 clk = ~clk;
    ysyx_23060096_exec_fsm #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .ifu_req(ifu_req), .ifu_rvalid(ifu_rvalid), .ir_we(ir_we),
        .inst_op(inst_op), .is_ebreak(is_ebreak), .dec_regwr(dec_regwr), .dec_memwr(dec_memwr),
        .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_ready(lsu_ready), .rf_we(rf_we), .pc_we(pc_we),
        .halt(halt), .illegal(illegal), .bus_err(bus_err), .cycle_cnt(cycle_cnt),
        .instret_cnt(instret_cnt)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic add(input logic r, input logic v, input logic [6:0] o, input logic e,
                       input logic w, input logic m, input logic d, input logic [8:0] f,
                       input logic [3:0] c, input logic [3:0] n);
        vec_t t;
        t.rst = r; t.rv = v; t.op = o; t.eb = e; t.rw = w; t.mw = m; t.rdy = d;
        t.flags = f; t.cyc = c; t.ret = n;
        vecs.push_back(t);
    endtask
    task automatic drive(input logic r, input logic v, input logic [6:0] o, input logic e,
                         input logic w, input logic m, input logic d);
        rst = r; ifu_rvalid = v; inst_op = o; is_ebreak = e;
        dec_regwr = w; dec_memwr = m; lsu_ready = d;
    endtask
    initial begin
        int pulses, rfp, n;
        drive(1, 0, ADDI, 0, 0, 0, 0);
        @(negedge clk);
        // reset, then an addi fetched immediately
        add(1,0,ADDI,0,1,0,0, Z, 0,0);  add(1,0,ADDI,0,1,0,0, Z, 0,0);
        add(0,0,ADDI,0,1,0,0, Z, 0,0);  add(0,1,ADDI,0,1,0,0, FI,0,0);
        add(0,0,ADDI,0,1,0,0, Z, 1,0);  add(0,0,ADDI,0,1,0,0, Z, 2,0);
        add(0,0,ADDI,0,1,0,0, WB,3,0);
        // load: one FETCH wait, then LSU ready on the 4th MEM cycle (timeout boundary)
        add(0,0,LOAD,0,1,0,0, F, 4,1);  add(0,1,LOAD,0,1,0,0, FI,5,1);
        add(0,0,LOAD,0,1,0,0, Z, 6,1);  add(0,0,LOAD,0,1,0,0, Z, 7,1);
        add(0,0,LOAD,0,1,0,0, M, 8,1);  add(0,0,LOAD,0,1,0,0, M, 9,1);
        add(0,0,LOAD,0,1,0,0, M,10,1);  add(0,0,LOAD,0,1,0,1, M,11,1);
        add(0,0,LOAD,0,1,0,0, WB,12,1);
        // store; cycle_cnt wraps 15 -> 0
        add(0,1,STORE,0,0,1,0, FI,13,2); add(0,0,STORE,0,0,1,0, Z,14,2);
        add(0,0,STORE,0,0,1,0, Z,15,2);  add(0,0,STORE,0,0,1,1, MW,0,2);
        add(0,0,STORE,0,0,1,0, P, 1,2);
        // illegal opcode with a stray lsu_ready, then rvalid ignored in HALT
        add(0,1,BAD,0,0,0,1, FI,2,3);   add(0,0,BAD,0,0,0,0, Z, 3,3);
        add(0,1,BAD,0,0,0,0, HI,4,3);   add(0,1,BAD,0,0,0,0, HI,4,3);
        add(1,1,BAD,0,0,0,0, HI,4,3);   add(0,0,BAD,0,0,0,0, Z, 0,0);
        // fetch timeout
        add(0,0,BAD,0,0,0,0, F, 0,0);   add(0,0,BAD,0,0,0,0, F, 1,0);
        add(0,0,BAD,0,0,0,0, F, 2,0);   add(0,0,BAD,0,0,0,0, F, 3,0);
        add(0,0,BAD,0,0,0,0, HB,4,0);   add(1,0,BAD,0,0,0,0, HB,4,0);
        add(0,0,BAD,0,0,0,0, Z, 0,0);
        // rvalid on the 4th wait cycle wins, then ebreak halts without a cause flag
        add(0,0,RTYP,0,1,0,0, F, 0,0);  add(0,0,RTYP,0,1,0,0, F, 1,0);
        add(0,0,RTYP,0,1,0,0, F, 2,0);  add(0,1,RTYP,0,1,0,0, FI,3,0);
        add(0,0,RTYP,0,1,0,0, Z, 4,0);  add(0,0,RTYP,0,1,0,0, Z, 5,0);
        add(0,0,RTYP,0,1,0,0, WB,6,0);  add(0,1,SYS,1,0,0,0, FI,7,1);
        add(0,0,SYS,1,0,0,0, Z, 8,1);   add(0,0,SYS,1,0,0,0, H, 9,1);
        add(1,0,SYS,1,0,0,0, H, 9,1);   add(0,0,SYS,0,0,0,0, Z, 0,0);
        // reset drops an outstanding fetch request
        add(0,0,SYS,0,0,0,0, F, 0,0);   add(1,0,SYS,0,0,0,0, F, 1,0);
        add(0,0,SYS,0,0,0,0, Z, 0,0);
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].rv, vecs[i].op, vecs[i].eb, vecs[i].rw, vecs[i].mw, vecs[i].rdy);
            #1;
            chk($sformatf("v%0d_flags", i),
                {ifu_req, ir_we, lsu_req, lsu_wen, rf_we, pc_we, halt, illegal, bus_err}, vecs[i].flags);
            chk($sformatf("v%0d_cycle_cnt", i), cycle_cnt, vecs[i].cyc);
            chk($sformatf("v%0d_instret_cnt", i), instret_cnt, vecs[i].ret);
            @(negedge clk);
        end
        // 16 back-to-back addi: both counters wrap to 0 and execution continues
        drive(1, 0, ADDI, 0, 1, 0, 0);
        @(negedge clk);
        drive(0, 1, ADDI, 0, 1, 0, 0);
        pulses = 0; rfp = 0;
        for (int i = 0; i < 200 && pulses < 16; i++) begin
            #1;
            if (pc_we) pulses++;
            if (rf_we) rfp++;
            @(negedge clk);
        end
        #1;
        chk("wrap_pc_we_pulses", pulses, 16);
        chk("wrap_rf_we_pulses", rfp, 16);
        chk("wrap_instret", instret_cnt, 0);
        chk("wrap_cycle", cycle_cnt, 0);
        chk("wrap_refetch", ifu_req, 1);
        n = 0;
        for (int i = 0; i < 20 && !pc_we; i++) begin
            @(negedge clk); #1; n++;
        end
        chk("wrap_17th_wb_cycles", n, 3);
        @(negedge clk); #1;
        chk("wrap_instret_after", instret_cnt, 1);
        // load whose LSU never answers: bus error after 4 MEM cycles
        @(negedge clk);
        drive(1, 0, LOAD, 0, 1, 0, 0);
        @(negedge clk);
        drive(0, 1, LOAD, 0, 1, 0, 0);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (halt) break;
            if (lsu_req) n++;
            @(negedge clk);
        end
        chk("memto_lsu_req_cycles", n, 4);
        chk("memto_halt", halt, 1);
        chk("memto_bus_err", bus_err, 1);
        chk("memto_illegal", illegal, 0);
        chk("memto_lsu_req_off", lsu_req, 0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
